// File: rtl/diff_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : diff_unpacker_pkg
// Brief    : Shared types and constant tables for the residue diff unpacker.
// Revision : 1.0 - initial release
// ============================================================================
package diff_unpacker_pkg;

    localparam int SYM_W     = 32;  // width of one output diff symbol
    localparam int NUM_SYM   = 8;   // symbols per block
    localparam int HDR_W     = 8;   // header byte at the bottom of beat 0
    localparam int BEAT_BITS = 64;  // input beat width
    localparam int MAX_BEATS = 5;   // longest block (code 7)
    localparam int BUF_W     = BEAT_BITS * MAX_BEATS;

    // Width code carried in hdr[2:0]
    typedef logic [2:0] wcode_t;

    // Block parser states
    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_COLLECT = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    // Symbol width in bits for each width code
    localparam int WIDTH_OF_CODE [8] = '{0, 2, 4, 6, 8, 12, 16, 32};

    // Beats per block = ceil((8 + 8w) / 64) for each width code
    localparam logic [2:0] BEATS_OF_CODE [8] = '{
        3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd5
    };

endpackage
`default_nettype wire

// File: rtl/diff_sym_extract.sv
`default_nettype none
// ============================================================================
// Module   : diff_sym_extract
// Brief    : Combinational slicer: picks eight w-bit residues out of the block
//            buffer and sign-extends each one to a 32-bit diff symbol.
// Revision : 1.0 - initial release
// ============================================================================
module diff_sym_extract
    import diff_unpacker_pkg::*;
(
    input  logic [BUF_W-1:0]           buf_i,
    input  wcode_t                     code_i,
    output logic [NUM_SYM*SYM_W-1:0]   sym_o
);

    localparam int W_C1 = WIDTH_OF_CODE[1];
    localparam int W_C2 = WIDTH_OF_CODE[2];
    localparam int W_C3 = WIDTH_OF_CODE[3];
    localparam int W_C4 = WIDTH_OF_CODE[4];
    localparam int W_C5 = WIDTH_OF_CODE[5];
    localparam int W_C6 = WIDTH_OF_CODE[6];
    localparam int W_C7 = WIDTH_OF_CODE[7];

    // The widest block ends at bit HDR_W + 8*32 - 1; the rest is beat padding.
    logic w_unused_pad;
    assign w_unused_pad = ^buf_i[BUF_W-1:HDR_W+NUM_SYM*W_C7];

    // One fixed slice pattern per width code; code 0 carries no payload.
    always_comb begin
        sym_o = '0;
        case (code_i)
            3'd1: for (int i = 0; i < NUM_SYM; i++)
                sym_o[SYM_W*i +: SYM_W] = {{(SYM_W-W_C1){buf_i[HDR_W+W_C1*i+W_C1-1]}},
                                           buf_i[HDR_W+W_C1*i +: W_C1]};
            3'd2: for (int i = 0; i < NUM_SYM; i++)
                sym_o[SYM_W*i +: SYM_W] = {{(SYM_W-W_C2){buf_i[HDR_W+W_C2*i+W_C2-1]}},
                                           buf_i[HDR_W+W_C2*i +: W_C2]};
            3'd3: for (int i = 0; i < NUM_SYM; i++)
                sym_o[SYM_W*i +: SYM_W] = {{(SYM_W-W_C3){buf_i[HDR_W+W_C3*i+W_C3-1]}},
                                           buf_i[HDR_W+W_C3*i +: W_C3]};
            3'd4: for (int i = 0; i < NUM_SYM; i++)
                sym_o[SYM_W*i +: SYM_W] = {{(SYM_W-W_C4){buf_i[HDR_W+W_C4*i+W_C4-1]}},
                                           buf_i[HDR_W+W_C4*i +: W_C4]};
            3'd5: for (int i = 0; i < NUM_SYM; i++)
                sym_o[SYM_W*i +: SYM_W] = {{(SYM_W-W_C5){buf_i[HDR_W+W_C5*i+W_C5-1]}},
                                           buf_i[HDR_W+W_C5*i +: W_C5]};
            3'd6: for (int i = 0; i < NUM_SYM; i++)
                sym_o[SYM_W*i +: SYM_W] = {{(SYM_W-W_C6){buf_i[HDR_W+W_C6*i+W_C6-1]}},
                                           buf_i[HDR_W+W_C6*i +: W_C6]};
            3'd7: for (int i = 0; i < NUM_SYM; i++)
                sym_o[SYM_W*i +: SYM_W] = buf_i[HDR_W+W_C7*i +: W_C7];
            default: sym_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/diff_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : diff_unpacker
// Brief    : Parses width-coded residue blocks from a 64-bit beat stream and
//            emits one registered 256-bit sign-extended diff vector per block.
// Revision : 1.0 - initial release
// ============================================================================
module diff_unpacker
    import diff_unpacker_pkg::*;
#(
    parameter int BEAT_W = 64,
    parameter int DIFF_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [BEAT_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DIFF_W-1:0] data_o,
    input  logic              ready_i,
    output logic              err_o
);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;      // beats still to come in this block
    wcode_t             code_q, code_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [DIFF_W-1:0]  data_q, data_d;
    logic               err_q, err_d;

    logic               w_load;            // entering S_OUT this cycle
    logic [2:0]         w_idx;             // buffer slot of the beat being collected
    logic [DIFF_W-1:0]  w_sym;

    // Next slot counts up from 1 while the remaining-beat counter counts down.
    assign w_idx = BEATS_OF_CODE[code_q] - cnt_q;

    // Extraction runs on the next-cycle buffer so the final beat is included.
    diff_sym_extract u_extract (
        .buf_i  (buf_d),
        .code_i (code_d),
        .sym_o  (w_sym)
    );

    // Block parser: header capture, beat collection, output hand-off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        buf_d   = buf_q;
        err_d   = err_q;
        w_load  = 1'b0;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            S_HDR: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    code_d            = data_i[2:0];
                    buf_d[BEAT_W-1:0] = data_i;
                    cnt_d             = BEATS_OF_CODE[data_i[2:0]] - 3'd1;
                    if (data_i[HDR_W-1:3] != '0) begin
                        err_d = 1'b1;
                    end
                    if (BEATS_OF_CODE[data_i[2:0]] == 3'd1) begin
                        state_d = S_OUT;
                        w_load  = 1'b1;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    case (w_idx)
                        3'd1:    buf_d[BEAT_W*1 +: BEAT_W] = data_i;
                        3'd2:    buf_d[BEAT_W*2 +: BEAT_W] = data_i;
                        3'd3:    buf_d[BEAT_W*3 +: BEAT_W] = data_i;
                        3'd4:    buf_d[BEAT_W*4 +: BEAT_W] = data_i;
                        default: buf_d = buf_q;
                    endcase
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_OUT;
                        w_load  = 1'b1;
                    end
                end
            end
            S_OUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // Output vector is captured once per block and held until consumed.
    always_comb begin
        data_d = data_q;
        if (w_load) begin
            data_d = w_sym;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_HDR;
            cnt_q   <= '0;
            code_q  <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign data_o = data_q;
    assign err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_diff_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_diff_unpacker
// Brief    : Directed self-checking bench for diff_unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_diff_unpacker;

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic [63:0]  data_i;
    logic         ready_o;
    logic         valid_o;
    logic [255:0] data_o;
    logic         ready_i;
    logic         err_o;

    int n_checks = 0;
    int n_errors = 0;

    diff_unpacker #(.BEAT_W(64), .DIFF_W(256)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait (bounded) for it to be accepted.
    task automatic send_beat(input logic [63:0] b);
        int n;
        n       = 0;
        valid_i = 1'b1;
        data_i  = b;
        while (!ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got ready_o=0 expected ready_o=1 within 50 cycles");
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic consume();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    logic [319:0] blk7;
    logic [255:0] exp7;
    logic [255:0] exp2;
    logic [255:0] exp4;
    logic [255:0] exp1;

    initial begin
        exp4 = {32'hFFFFFF80, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'hFFFFFFFF, 32'h1};
        exp7 = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        exp2 = {32'hFFFFFFFA, 32'h3, 32'hFFFFFFF9, 32'h1,
                32'h0, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h7};
        exp1 = {32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1,
                32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
        blk7 = '0;
        blk7[7:0] = 8'h07;
        blk7[8 +: 256] = exp7;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", valid_o, 1'b0);
        check_eq("rst_data",  data_o,  '0);
        check_eq("rst_err",   err_o,   1'b0);
        check_eq("rst_ready", ready_o, 1'b1);
        rst_n = 1'b1;
        tick();

        // Code 0: single beat, all-zero vector
        send_beat(64'h0);
        check_eq("c0_valid", valid_o, 1'b1);
        check_eq("c0_data",  data_o,  '0);
        check_eq("c0_err",   err_o,   1'b0);
        consume();
        check_eq("c0_valid_after", valid_o, 1'b0);

        // Code 4: two beats, 8-bit symbols
        send_beat(64'h0605_0403_02FF_0104);
        check_eq("c4_mid_valid", valid_o, 1'b0);
        send_beat(64'h0000_0000_0000_0080);
        check_eq("c4_valid", valid_o, 1'b1);
        check_eq("c4_data",  data_o,  exp4);
        check_eq("c4_ready", ready_o, 1'b0);
        consume();

        // Code 7: five beats with stalls between them
        for (int k = 0; k < 5; k++) begin
            send_beat(blk7[64*k +: 64]);
            if (k < 4) begin
                check_eq("c7_mid_valid", valid_o, 1'b0);
                tick();
                tick();
            end
        end
        check_eq("c7_valid", valid_o, 1'b1);
        check_eq("c7_data",  data_o,  exp7);
        check_eq("c7_ready", ready_o, 1'b0);

        // Backpressure: input offered but must not be taken while output held
        valid_i = 1'b1;
        data_i  = 64'hDEAD_BEEF_0000_0005;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("bp_data",  data_o,  exp7);
            check_eq("bp_ready", ready_o, 1'b0);
        end
        check_eq("bp_valid", valid_o, 1'b1);
        valid_i = 1'b0;
        consume();
        check_eq("bp_release_valid", valid_o, 1'b0);

        // Code 2 after release
        send_beat(64'h0000_00A3_910F_8702);
        check_eq("c2_data", data_o, exp2);
        check_eq("c2_err",  err_o,  1'b0);
        consume();

        // Reserved header bits set: error is sticky, data still decoded as w=2
        send_beat(64'h0000_0000_006D_39F9);
        check_eq("err_data", data_o, exp1);
        check_eq("err_set",  err_o,  1'b1);
        consume();
        send_beat(64'h0);
        check_eq("err_sticky_data", data_o, '0);
        check_eq("err_sticky",      err_o,  1'b1);
        consume();

        // Reset in the middle of a 3-beat block
        send_beat(64'h1234_5678_9ABC_DE06);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_valid", valid_o, 1'b0);
        check_eq("mid_rst_data",  data_o,  '0);
        check_eq("mid_rst_err",   err_o,   1'b0);
        check_eq("mid_rst_ready", ready_o, 1'b1);
        rst_n = 1'b1;
        tick();
        send_beat(64'h0000_00A3_910F_8702);
        check_eq("post_rst_valid", valid_o, 1'b1);
        check_eq("post_rst_data",  data_o,  exp2);
        check_eq("post_rst_err",   err_o,   1'b0);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/diff_unpacker.md
# diff_unpacker

Upstream feeder of the decompressor's detransformer stage. Accepts the compressed residue stream as 64-bit beats under valid/ready, parses a per-block width header, sign-extends eight packed residue symbols to 32 bits each and presents one 256-bit diff vector per block, held stable until consumed. One block in, one 256-bit diff out; the detransformer reconstructs data from `data_o`.

## Interface
- `BEAT_W`, 64: input beat width; fixed, other values unsupported.
- `DIFF_W`, 256: output diff vector width, 8 symbols x 32 bits; fixed.
- `clk  in  1`: single clock, all state on rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `valid_i  in  1`: input beat valid.
- `data_i  in  64`: input beat.
- `ready_o  out  1`: block accepts beat this cycle.
- `valid_o  out  1`: `data_o` holds a complete diff vector.
- `data_o  out  256`: diff vector, symbol i at `[32i+31:32i]`.
- `ready_i  in  1`: downstream consumes `data_o` this cycle.
- `err_o  out  1`: sticky format error, cleared only by reset.

## Operation
- Block format: header byte at bits `[7:0]` of first beat; `hdr[2:0]` = width code, `hdr[7:3]` reserved, must be 0.
- Width code -> symbol width w: 0->0, 1->2, 2->4, 3->6, 4->8, 5->12, 6->16, 7->32.
- Beats per block = ceil((8+8w)/64): codes 0-3 ->1, 4-5 ->2, 6 ->3, 7 ->5.
- Beat k fills buffer bits `[64k+63:64k]`, buffer 320 bits.
- Symbol i occupies buffer bits `[8+w*i+w-1 : 8+w*i]`, sign-extended to 32 bits, placed at `data_o[32i+31:32i]`. w=0 gives all-zero vector. Padding bits beyond `8+8w` ignored.
- Every block starts on a beat boundary; no bits carry between blocks.
- FSM:
  - S_HDR: `ready_o`=1; on handshake latch code, store beat 0, set beat counter = beats-1; go S_OUT if 1 beat else S_COLLECT.
  - S_COLLECT: `ready_o`=1; each handshake stores beat at counter index, decrements; on final beat go S_OUT.
  - S_OUT: `ready_o`=0, `valid_o`=1; on `ready_i` go S_HDR.
- `data_o` registered, loaded on entry to S_OUT from buffer including final beat; stable while `valid_o`=1.
- `hdr[7:3]`≠0: set `err_o`, decode block normally using `hdr[2:0]`.
- Stale buffer bits from earlier blocks never influence output; unused beat slots are don't-care since the extraction mux never reaches them.

## Timing
- Reset (`rst_n`=0 at edge): state S_HDR, `valid_o`=0, `data_o`=0, `err_o`=0, counter 0; `ready_o`=1 from the first cycle after reset. Partial block in progress is discarded.
- Latency: final beat accepted at edge N -> `valid_o`=1 after edge N, i.e. valid during cycle N+1.
- Throughput: one beat per cycle while collecting; one bubble (S_OUT handshake cycle) between blocks; no input accepted while `valid_o`=1.
- `valid_i`=0 in S_COLLECT: stall, counter and buffer hold.
- `ready_i`=0 in S_OUT: hold `data_o`/`valid_o` indefinitely.
- `ready_i` while `valid_o`=0: ignored.
- `ready_o` depends on state only, never on `valid_i`.

## Structure
- Package `diff_unpacker_pkg`: width-code typedef (3 bits), FSM state enum, constant tables `WIDTH_OF_CODE[8]` and `BEATS_OF_CODE[8]`, `SYM_W`=32, `NUM_SYM`=8, `HDR_W`=8.
- Sub-module `diff_sym_extract`: combinational, inputs 320-bit buffer and code, outputs 256-bit sign-extended vector; one case per width code, 8 fixed slices each.
- Top holds FSM, beat counter, buffer registers, output register, error flag.

## Test plan
- Code 0: beat `0x0000_0000_0000_0000` -> one cycle later `valid_o`=1, `data_o`=0, `err_o`=0.
- Code 4 (w=8): beat0 `0x0605_0403_02FF_0104`, beat1 `0x...80` -> word0 `0x00000001`, word1 `0xFFFFFFFF`, words 2-6 `0x2..0x6`, word7 `0xFFFFFF80`.
- Code 7 (w=32): 5 beats, symbols `0x11111111..0x88888888` -> `data_o` matches exactly; `valid_o` rises the cycle after beat 4; `ready_o` low during S_OUT.
- Backpressure: `ready_i`=0 for 10 cycles with `valid_i`=1 -> `data_o` stable, no beats accepted; next block decodes correctly after release.
- Header `0xF9` (reserved set, code 1, w=2) -> `err_o`=1 and stays 1 across later clean blocks until reset; data still decoded as w=2.
- `rst_n`=0 after beat 1 of a 3-beat block -> all outputs zero; a fresh code-2 block then decodes correctly with no residue from the aborted block.
